rtc_alarm_core: RTL

Hardware timekeeper that replaces software-driven digit PIOs: keeps HH:MM:SS in BCD from a prescaled system clock, drives the six display digits, and supports N parametrised alarms with snooze, dismiss and auto-timeout. It sits between the Qsys PIO/bus side (time set, alarm writes, buttons) and the seven-segment encoder and jukebox/PWM player, which consume ring/ring_id. Time is always held internally in 24 h format; 12 h display is an output mode.

---
 rtl/rtc_pkg.sv | 46 ++++
 rtl/bcd_time_counter.sv | 72 +++++++
 rtl/rtc_alarm_core.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared types and helpers for the RTC alarm core
package rtc_pkg;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t h1;
        bcd_t h0;
        bcd_t m1;
        bcd_t m0;
        bcd_t s1;
        bcd_t s0;
    } hms_t;

    typedef struct packed {
        bcd_t h1;
        bcd_t h0;
        bcd_t m1;
        bcd_t m0;
        logic en;
    } alarm_t;

    typedef enum logic [1:0] {
        IDLE,
        RINGING,
        SNOOZED
    } ring_state_e;

    // Index/counter width that never collapses to zero bits.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // True when every digit is legal BCD and the value is a real 24 h time.
    function automatic logic bcd_valid(input hms_t t);
        logic ok;
        ok = (t.h1 <= 4'd2) && (t.h0 <= 4'd9) &&
             (t.m1 <= 4'd5) && (t.m0 <= 4'd9) &&
             (t.s1 <= 4'd5) && (t.s0 <= 4'd9);
        if ((t.h1 == 4'd2) && (t.h0 > 4'd3)) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_time_counter.sv
// rtl/bcd_time_counter.sv - HH:MM:SS BCD time register with tick carry chain and load
// Ports: clk_i/rst_ni clock and async active-low reset; tick_i advance one second;
//        load_i/load_val_i load a pre-validated time (wins over tick_i);
//        time_o current time; time_adv_o current time advanced by one second.
module bcd_time_counter
    import rtc_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        tick_i,
    input  logic        load_i,
    input  logic [23:0] load_val_i,
    output logic [23:0] time_o,
    output logic [23:0] time_adv_o
);

    hms_t time_q, time_d, adv;

    always_comb begin
        adv = time_q;
        if (time_q.s0 != 4'd9) begin
            adv.s0 = time_q.s0 + 4'd1;
        end else begin
            adv.s0 = 4'd0;
            if (time_q.s1 != 4'd5) begin
                adv.s1 = time_q.s1 + 4'd1;
            end else begin
                adv.s1 = 4'd0;
                if (time_q.m0 != 4'd9) begin
                    adv.m0 = time_q.m0 + 4'd1;
                end else begin
                    adv.m0 = 4'd0;
                    if (time_q.m1 != 4'd5) begin
                        adv.m1 = time_q.m1 + 4'd1;
                    end else begin
                        adv.m1 = 4'd0;
                        if ((time_q.h1 == 4'd2) && (time_q.h0 == 4'd3)) begin
                            adv.h1 = 4'd0;
                            adv.h0 = 4'd0;
                        end else if (time_q.h0 == 4'd9) begin
                            adv.h0 = 4'd0;
                            adv.h1 = time_q.h1 + 4'd1;
                        end else begin
                            adv.h0 = time_q.h0 + 4'd1;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        time_d = time_q;
        if (load_i) begin
            time_d = hms_t'(load_val_i);
        end else if (tick_i) begin
            time_d = adv;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            time_q <= '0;
        end else begin
            time_q <= time_d;
        end
    end

    assign time_o     = time_q;
    assign time_adv_o = adv;

endmodule

// File: rtl/rtc_alarm_core.sv
// rtl/rtc_alarm_core.sv - BCD real-time clock with N alarms, snooze, dismiss and ring timeout
// Ports: clk_clk/reset_reset_n clock and async active-low reset;
//        set_valid/set_bcd time load; alarm_wr/alarm_sel/alarm_bcd/alarm_en_in alarm write;
//        mode_12h display mode; snooze/dismiss ring control pulses;
//        hour1..second0/pm registered display; tick_1hz second pulse;
//        set_err rejected write pulse; ring/ring_id sounding alarm.
module rtc_alarm_core
    import rtc_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int N_ALARMS   = 2,
    parameter int SNOOZE_SEC = 300,
    parameter int RING_SEC   = 60
) (
    input  logic                          clk_clk,
    input  logic                          reset_reset_n,
    input  logic                          set_valid,
    input  logic [23:0]                   set_bcd,
    input  logic                          alarm_wr,
    input  logic [width_of(N_ALARMS)-1:0] alarm_sel,
    input  logic [15:0]                   alarm_bcd,
    input  logic                          alarm_en_in,
    input  logic                          mode_12h,
    input  logic                          snooze,
    input  logic                          dismiss,
    output logic [3:0]                    hour1,
    output logic [3:0]                    hour0,
    output logic [3:0]                    minute1,
    output logic [3:0]                    minute0,
    output logic [3:0]                    second1,
    output logic [3:0]                    second0,
    output logic                          pm,
    output logic                          tick_1hz,
    output logic                          set_err,
    output logic                          ring,
    output logic [width_of(N_ALARMS)-1:0] ring_id
);

    localparam int AW   = width_of(N_ALARMS);
    localparam int PW   = width_of(CLK_HZ);
    localparam int TMAX = (SNOOZE_SEC > RING_SEC) ? SNOOZE_SEC : RING_SEC;
    localparam int TW   = width_of(TMAX + 1);

    logic [PW-1:0] presc_q, presc_d;
    logic          tick, tick_eff, set_ok, wr_ok, load;
    hms_t          cur_time, adv_time;
    alarm_t        alarm_q [N_ALARMS];
    logic          match;
    logic [AW-1:0] match_id;
    ring_state_e   state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [AW-1:0] ring_id_q, ring_id_d;
    logic          ring_q, set_err_q;
    hms_t          disp_q, disp_d;
    logic          pm_q, pm_d;
    logic [4:0]    hour_bin, hour_12;

    assign tick   = (presc_q == PW'(CLK_HZ - 1));
    assign set_ok = bcd_valid(hms_t'(set_bcd));
    assign load   = set_valid && set_ok;
    assign wr_ok  = bcd_valid(hms_t'({alarm_bcd, 8'h00})) &&
                    ({1'b0, alarm_sel} < (AW + 1)'(N_ALARMS));
    // A tick coinciding with an accepted set is dropped everywhere, not just in the counter.
    assign tick_eff = tick && !load;

    assign presc_d = (load || tick) ? '0 : presc_q + PW'(1);

    bcd_time_counter u_time (
        .clk_i      (clk_clk),
        .rst_ni     (reset_reset_n),
        .tick_i     (tick_eff),
        .load_i     (load),
        .load_val_i (set_bcd),
        .time_o     (cur_time),
        .time_adv_o (adv_time)
    );

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        match    = 1'b0;
        match_id = '0;
        for (int i = N_ALARMS - 1; i >= 0; i--) begin
            if (alarm_q[i].en && (adv_time.s1 == 4'd0) && (adv_time.s0 == 4'd0) &&
                ({alarm_q[i].h1, alarm_q[i].h0, alarm_q[i].m1, alarm_q[i].m0} ==
                 {adv_time.h1, adv_time.h0, adv_time.m1, adv_time.m0})) begin
                match    = 1'b1;
                match_id = AW'(i);
            end
        end
    end

    // One timer serves both the ring timeout and the snooze countdown.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        ring_id_d = ring_id_q;
        case (state_q)
            IDLE: begin
                if (tick_eff && match) begin
                    state_d   = RINGING;
                    timer_d   = TW'(RING_SEC);
                    ring_id_d = match_id;
                end
            end
            RINGING: begin
                if (dismiss) begin
                    state_d = IDLE;
                end else if (snooze) begin
                    state_d = SNOOZED;
                    timer_d = TW'(SNOOZE_SEC);
                end else if (tick_eff) begin
                    if (timer_q <= TW'(1)) begin
                        state_d = IDLE;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
            end
            SNOOZED: begin
                if (dismiss) begin
                    state_d = IDLE;
                end else if (tick_eff) begin
                    if (timer_q <= TW'(1)) begin
                        state_d = RINGING;
                        timer_d = TW'(RING_SEC);
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        disp_d   = cur_time;
        pm_d     = 1'b0;
        hour_bin = 5'(cur_time.h1) * 5'd10 + 5'(cur_time.h0);
        hour_12  = hour_bin;
        if (hour_bin == 5'd0) begin
            hour_12 = 5'd12;
        end else if (hour_bin > 5'd12) begin
            hour_12 = hour_bin - 5'd12;
        end
        if (mode_12h) begin
            pm_d = (hour_bin >= 5'd12);
            if (hour_12 >= 5'd10) begin
                disp_d.h1 = 4'd1;
                disp_d.h0 = 4'(hour_12 - 5'd10);
            end else begin
                disp_d.h1 = 4'd0;
                disp_d.h0 = 4'(hour_12);
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            presc_q   <= '0;
            state_q   <= IDLE;
            timer_q   <= '0;
            ring_id_q <= '0;
            ring_q    <= 1'b0;
            set_err_q <= 1'b0;
            disp_q    <= '0;
            pm_q      <= 1'b0;
            for (int i = 0; i < N_ALARMS; i++) begin
                alarm_q[i] <= '0;
            end
        end else begin
            presc_q   <= presc_d;
            state_q   <= state_d;
            timer_q   <= timer_d;
            ring_id_q <= ring_id_d;
            ring_q    <= (state_d == RINGING);
            set_err_q <= (set_valid && !set_ok) || (alarm_wr && !wr_ok);
            disp_q    <= disp_d;
            pm_q      <= pm_d;
            if (alarm_wr && wr_ok) begin
                alarm_q[alarm_sel] <= alarm_t'({alarm_bcd, alarm_en_in});
            end
        end
    end

    assign hour1    = disp_q.h1;
    assign hour0    = disp_q.h0;
    assign minute1  = disp_q.m1;
    assign minute0  = disp_q.m0;
    assign second1  = disp_q.s1;
    assign second0  = disp_q.s0;
    assign pm       = pm_q;
    assign tick_1hz = tick;
    assign set_err  = set_err_q;
    assign ring     = ring_q;
    assign ring_id  = ring_id_q;

endmodule
